// File: rtl/jpeg_pkg.sv
// Shared definitions for the streaming quantise/zigzag stage.
// Contents: read FSM state enum, default reciprocal constant and the
// symmetric saturation magnitude helper.
package jpeg_pkg;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  // All-ones reciprocal: identity quantisation for |x| < 2^(w-1).
  function automatic logic [63:0] recip_default(input int unsigned w);
    return (64'(1) << w) - 64'(1);
  endfunction

  // Positive saturation magnitude; the negative limit is its negation.
  function automatic logic [63:0] sat_limit(input int unsigned w);
    return (64'(1) << (w - 1)) - 64'(1);
  endfunction

endpackage

// File: rtl/zigzag_addr_gen.sv
// Read-order generator: walks an BLK x BLK block by row/column.
// Ports: clk, reset (async, active-high); mode (1 = zigzag, 0 = raster);
// first (current beat is beat 0 of a block); step (advance past the current
// beat); idx_c (raster index of the current beat, combinational).
module zigzag_addr_gen #(
  parameter int unsigned BLK   = 8,
  parameter int unsigned IDX_W = $clog2(BLK * BLK)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             first,
  input  logic             step,
  output logic [IDX_W-1:0] idx_c
);

  localparam int unsigned RC_W = IDX_W / 2;
  localparam logic [RC_W-1:0] EDGE = RC_W'(BLK - 1);

  logic [RC_W-1:0] row, col, cur_row, cur_col, nxt_row, nxt_col;
  logic            up, cur_up, nxt_up;

  // Current position (beat 0 forces origin) and its successor.
  always_comb begin
    cur_row = first ? '0 : row;
    cur_col = first ? '0 : col;
    cur_up  = first ? 1'b1 : up;
    idx_c   = {cur_row, cur_col};
    nxt_row = cur_row;
    nxt_col = cur_col;
    nxt_up  = cur_up;
    if (!mode) begin
      if (cur_col == EDGE) begin
        nxt_row = cur_row + RC_W'(1);
        nxt_col = '0;
      end else begin
        nxt_col = cur_col + RC_W'(1);
      end
    end else if (cur_up) begin
      // Moving up-right; right edge is checked first so the corner turns down.
      if (cur_col == EDGE) begin
        nxt_row = cur_row + RC_W'(1);
        nxt_up  = 1'b0;
      end else if (cur_row == '0) begin
        nxt_col = cur_col + RC_W'(1);
        nxt_up  = 1'b0;
      end else begin
        nxt_row = cur_row - RC_W'(1);
        nxt_col = cur_col + RC_W'(1);
      end
    end else begin
      // Moving down-left; bottom edge is checked first for the same reason.
      if (cur_row == EDGE) begin
        nxt_col = cur_col + RC_W'(1);
        nxt_up  = 1'b1;
      end else if (cur_col == '0) begin
        nxt_row = cur_row + RC_W'(1);
        nxt_up  = 1'b1;
      end else begin
        nxt_row = cur_row + RC_W'(1);
        nxt_col = cur_col - RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
      up  <= 1'b1;
    end else if (step) begin
      row <= nxt_row;
      col <= nxt_col;
      up  <= nxt_up;
    end
  end

endmodule

// File: rtl/jpeg_quant_zigzag_stream.sv
// Streaming quantiser: raster-order coefficients in, quantised block out in
// zigzag or raster order through a two-bank ping-pong store.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_data/zigzag_en
// input stream; qt_wr_en/qt_addr/qt_data reciprocal table write;
// out_valid/out_ready/out_data/out_index/out_first/out_last/out_nz_count
// output stream with block markers and block nonzero count.
module jpeg_quant_zigzag_stream
  import jpeg_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BLK     = 8,
  parameter int unsigned RECIP_W = 16,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned IDX_W   = $clog2(BLK * BLK)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               zigzag_en,
  input  logic               qt_wr_en,
  input  logic [IDX_W-1:0]   qt_addr,
  input  logic [RECIP_W-1:0] qt_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_first,
  output logic               out_last,
  output logic [IDX_W:0]     out_nz_count
);

  localparam int unsigned N      = BLK * BLK;
  localparam int unsigned PROD_W = DATA_W + RECIP_W;
  localparam logic [RECIP_W-1:0] RECIP_DEF = RECIP_W'(recip_default(RECIP_W));
  localparam logic [DATA_W-1:0]  SAT_MAG   = DATA_W'(sat_limit(OUT_W));
  localparam logic [PROD_W-1:0]  HALF      = PROD_W'(1) << (RECIP_W - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]   PEN_IDX   = IDX_W'(N - 2);

  logic [RECIP_W-1:0] recip [N];
  logic [OUT_W-1:0]   mem   [2][N];
  logic [IDX_W:0]     nz    [2];
  logic [1:0]         full, full_n, zz;
  logic               wr_bank, rd_bank;
  logic [IDX_W-1:0]   wr_cnt, rd_cnt;
  rd_state_e          state;

  logic               acc_c, neg_c, ld_c, ld_first_c, ld_bank_c, free_c;
  logic [DATA_W-1:0]  mag_c, rnd_c;
  logic [PROD_W-1:0]  prod_c;
  logic [OUT_W-1:0]   sat_c, q_c;
  logic [IDX_W-1:0]   rd_idx_c;

  assign acc_c = in_valid && in_ready;

  // Sign-magnitude multiply by reciprocal, round half away from zero, saturate.
  always_comb begin
    neg_c  = in_data[DATA_W-1];
    mag_c  = neg_c ? (~in_data + DATA_W'(1)) : in_data;
    prod_c = PROD_W'(mag_c) * PROD_W'(recip[wr_cnt]) + HALF;
    rnd_c  = DATA_W'(prod_c >> RECIP_W);
    sat_c  = (rnd_c > SAT_MAG) ? OUT_W'(SAT_MAG) : OUT_W'(rnd_c);
    q_c    = neg_c ? (~sat_c + OUT_W'(1)) : sat_c;
  end

  // Read-side decisions: whether to present a new beat, from which bank.
  always_comb begin
    ld_c       = 1'b0;
    ld_first_c = 1'b0;
    ld_bank_c  = rd_bank;
    free_c     = 1'b0;
    case (state)
      RD_IDLE: begin
        ld_c       = full[rd_bank];
        ld_first_c = 1'b1;
      end
      RD_STREAM: begin
        if (out_ready) begin
          if (out_last) begin
            free_c     = 1'b1;
            ld_bank_c  = ~rd_bank;
            ld_c       = full[ld_bank_c];
            ld_first_c = 1'b1;
          end else begin
            ld_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // A free and a fill can land on the same edge; both are applied.
  always_comb begin
    full_n = full;
    if (free_c) full_n[rd_bank] = 1'b0;
    if (acc_c && (wr_cnt == LAST_IDX)) full_n[wr_bank] = 1'b1;
  end

  zigzag_addr_gen #(
    .BLK   (BLK),
    .IDX_W (IDX_W)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .mode  (zz[ld_bank_c]),
    .first (ld_first_c),
    .step  (ld_c),
    .idx_c (rd_idx_c)
  );

  // Reciprocal table; an accept on the same edge sees the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) recip[i] <= RECIP_DEF;
    end else if (qt_wr_en) begin
      recip[qt_addr] <= qt_data;
    end
  end

  // Coefficient store, no reset needed: banks are gated by the full flags.
  always_ff @(posedge clk) begin
    if (acc_c) mem[wr_bank][wr_cnt] <= q_c;
  end

  // Write side: counters, bank flags, per-bank order latch and nonzero count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= '0;
      in_ready <= 1'b1;
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      zz       <= '0;
      nz[0]    <= '0;
      nz[1]    <= '0;
    end else begin
      full     <= full_n;
      in_ready <= ~&full_n;
      if (acc_c) begin
        if (wr_cnt == '0) begin
          zz[wr_bank] <= zigzag_en;
          nz[wr_bank] <= (IDX_W + 1)'(q_c != '0);
        end else begin
          nz[wr_bank] <= nz[wr_bank] + (IDX_W + 1)'(q_c != '0);
        end
        if (wr_cnt == LAST_IDX) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + IDX_W'(1);
        end
      end
    end
  end

  // Read FSM with registered output beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RD_IDLE;
      rd_bank      <= 1'b0;
      rd_cnt       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      out_nz_count <= '0;
    end else if (ld_c) begin
      state     <= RD_STREAM;
      rd_bank   <= ld_bank_c;
      out_valid <= 1'b1;
      out_data  <= mem[ld_bank_c][rd_idx_c];
      out_index <= rd_idx_c;
      out_first <= ld_first_c;
      out_last  <= !ld_first_c && (rd_cnt == PEN_IDX);
      rd_cnt    <= ld_first_c ? '0 : rd_cnt + IDX_W'(1);
      if (ld_first_c) out_nz_count <= nz[ld_bank_c];
    end else if (free_c) begin
      state     <= RD_IDLE;
      rd_bank   <= ~rd_bank;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jpeg_quant_zigzag_stream.sv
// Self-checking bench: randomized blocks scored against a behavioural model
// built from the quantisation arithmetic and a diagonal-sweep zigzag order.
module tb_jpeg_quant_zigzag_stream;

  localparam int BLK = 8;
  localparam int N = BLK * BLK;
  localparam int RECIP_W = 16;
  localparam int QMAX = 32767;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        zigzag_en = 1'b0;
  logic        qt_wr_en = 1'b0;
  logic [5:0]  qt_addr = '0;
  logic [15:0] qt_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [5:0]  out_index;
  logic        out_first;
  logic        out_last;
  logic [6:0]  out_nz_count;

  jpeg_quant_zigzag_stream dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .zigzag_en    (zigzag_en),
    .qt_wr_en     (qt_wr_en),
    .qt_addr      (qt_addr),
    .qt_data      (qt_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_first    (out_first),
    .out_last     (out_last),
    .out_nz_count (out_nz_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    bit first;
    bit last;
    int nz;
  } beat_t;

  beat_t exp_q[$];
  int    gaps[$];
  int    tbl[N];
  int    blk[N];
  int    zz_ord[N];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_hs_cyc = 0;
  int    hs_total = 0;
  int    acc_total = 0;
  int    rdy_mode = 2;  // 0 random, 1 stall, 2 always ready

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int quant(input longint x, input longint r);
    longint m, v;
    m = (x < 0) ? -x : x;
    v = (m * r + (longint'(1) << (RECIP_W - 1))) >> RECIP_W;
    if (v > QMAX) v = QMAX;
    return (x < 0) ? -int'(v) : int'(v);
  endfunction

  task automatic push_model(input bit zz);
    int q[N];
    int nzc;
    int idx;
    beat_t b;
    nzc = 0;
    for (int i = 0; i < N; i++) begin
      q[i] = quant(longint'(blk[i]), longint'(tbl[i]));
      if (q[i] != 0) nzc++;
    end
    for (int k = 0; k < N; k++) begin
      idx     = zz ? zz_ord[k] : k;
      b.data  = q[idx];
      b.idx   = idx;
      b.first = (k == 0);
      b.last  = (k == N - 1);
      b.nz    = nzc;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_block(input bit zz, input bit push, input int n);
    int w;
    if (push) push_model(zz);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_data   = blk[i];
      zigzag_en = zz;
      w = 0;
      while (!in_ready) begin
        @(negedge clk);
        w++;
        if (w > 20000) begin
          $display("FAIL in_ready_timeout: got 0 expected 1");
          $fatal(1, "input stalled");
        end
      end
      @(posedge clk);
      @(negedge clk);
      acc_total++;
    end
    in_valid = 1'b0;
  endtask

  task automatic qt_write(input int addr, input int data);
    qt_wr_en = 1'b1;
    qt_addr  = 6'(addr);
    qt_data  = 16'(data);
    @(posedge clk);
    @(negedge clk);
    qt_wr_en  = 1'b0;
    tbl[addr] = data;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic int rnd_coef();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 400)) - 200;
      1: return int'($urandom_range(0, 131072)) - 65536;
      2: return int'($urandom);
      default: return 0;
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) blk[i] = rnd_coef();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: choose ready, then score the beat consumed at the next edge.
  always @(negedge clk) begin
    beat_t e;
    if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = (rdy_mode == 2);
    if (!reset && out_valid && out_ready) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("data", longint'($signed(out_data)), e.data);
        check("index", out_index, e.idx);
        check("first", out_first, e.first);
        check("last", out_last, e.last);
        check("nz_count", out_nz_count, e.nz);
        if (out_first) gaps.push_back(cyc - last_hs_cyc);
        if (out_last) last_hs_cyc = cyc;
      end
    end
  end

  initial begin
    int k, acc0, hs0, w;
    k = 0;
    for (int s = 0; s <= 2 * BLK - 2; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < BLK ? s : BLK - 1); r >= (s - BLK + 1 > 0 ? s - BLK + 1 : 0); r--)
          zz_ord[k++] = r * BLK + (s - r);
      end else begin
        for (int r = (s - BLK + 1 > 0 ? s - BLK + 1 : 0); r <= (s < BLK ? s : BLK - 1); r++)
          zz_ord[k++] = r * BLK + (s - r);
      end
    end
    for (int i = 0; i < N; i++) tbl[i] = 65535;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_nz", out_nz_count, 0);

    // Ramp block, default table, zigzag order.
    for (int i = 0; i < N; i++) blk[i] = i;
    send_block(1'b1, 1'b1, N);
    drain();

    // Q=16 at entry 0: rounding cases.
    qt_write(0, 4096);
    foreach (blk[i]) blk[i] = int'($urandom_range(0, 200)) - 100;
    blk[0] = 56;  send_block(1'b1, 1'b1, N);
    blk[0] = -40; send_block(1'b1, 1'b1, N);
    blk[0] = 8;   send_block(1'b0, 1'b1, N);
    drain();
    qt_write(0, 65535);

    // Saturation at both signs and the most negative input.
    fill_random();
    blk[0] = 100000;
    blk[1] = -100000;
    blk[2] = int'(32'h8000_0000);
    blk[3] = 32767;
    blk[4] = -32767;
    send_block(1'b1, 1'b1, N);
    drain();

    // Raster block followed by zigzag block.
    fill_random();
    send_block(1'b0, 1'b1, N);
    fill_random();
    send_block(1'b1, 1'b1, N);
    drain();

    // Random tables, data, order and downstream backpressure.
    rdy_mode = 0;
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(0, 4)) qt_write(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 65535)));
      fill_random();
      send_block(1'($urandom_range(0, 1)), 1'b1, N);
    end
    drain();

    // Three blocks against a stalled sink, then release.
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    rdy_mode = 1;
    gaps.delete();
    acc0 = acc_total;
    hs0  = hs_total;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          fill_random();
          send_block(1'(b % 2), 1'b1, N);
        end
      end
    join_none
    w = 0;
    while (acc_total - acc0 < 128 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_accepted", acc_total - acc0, 128);
    rdy_mode = 2;
    w = 0;
    while (acc_total - acc0 < 192 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    drain();
    check("bp_beats", hs_total - hs0, 192);
    check("bp_blocks", gaps.size(), 3);
    if (gaps.size() >= 2) check("bp_no_bubble", gaps[1], 1);

    // Reset with a full block held and a partial block in flight.
    qt_write(3, 1000);
    rdy_mode = 1;
    fill_random();
    send_block(1'b1, 1'b0, N);
    send_block(1'b1, 1'b0, 20);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_nz", out_nz_count, 0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) tbl[i] = 65535;
    rdy_mode = 2;
    @(negedge clk);
    fill_random();
    blk[3] = 5000;
    send_block(1'b1, 1'b1, N);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
